pipe_hazard_ctrl: RTL and testbench

- Central hazard and flush sequencer for the RV12 six-stage pipeline (IF, PD, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of in-flight destination registers in EX, MEM and WB.
- Per cycle it decides, for each ID source operand, whether to read the regfile, bypass from a later stage, or stall.
- Sequences PD/ID flushes on branch mispredict (bu_flush) and exceptions, replacing ad-hoc stall/flush glue between id_unit, ex_units and int_rf.

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush sequencer for the six-stage pipeline: shadow scoreboard of EX/MEM/WB destinations.
// Latency: stall, flush and bypass selects are combinational from the inputs and the shadow registers.
// Backpressure: id_stall_o/pd_stall_o hold PD/ID and inject an EX bubble; ex_busy_i freezes the EX entry.
//
// Ports:
//   clk, rst                    : core clock, synchronous active-high reset (forces all outputs to 0)
//   id_*_i                      : ID-stage instruction descriptor (valid, sources, destination, load flag)
//   ex_busy_i                   : EX multicycle unit holding its instruction
//   bu_flush_i, ex_exception_i  : branch redirect, exception raised in EX
//   id_stall_o, pd_stall_o      : hold PD/ID (identical)
//   flush_pd_o, flush_id_o      : kill PD/ID contents (identical)
//   byp_rs1_sel_o/byp_rs2_sel_o : operand source, 0=RF 1=EX 2=MEM 3=WB
//   drain_o                     : draining older instructions after an exception
module pipe_hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic                 id_rs1_used_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_we_i,
  input  logic                 id_is_load_i,
  input  logic                 ex_busy_i,
  input  logic                 bu_flush_i,
  input  logic                 ex_exception_i,
  output logic                 id_stall_o,
  output logic                 pd_stall_o,
  output logic                 flush_pd_o,
  output logic                 flush_id_o,
  output logic [1:0]           byp_rs1_sel_o,
  output logic [1:0]           byp_rs2_sel_o,
  output logic                 drain_o
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Shadow entries: {valid, rd, we, load} for EX, MEM, WB.
  logic                 r_ex_vld, r_ex_we, r_ex_ld;
  logic [REG_IDX_W-1:0] r_ex_rd;
  logic                 r_mem_vld, r_mem_we, r_mem_ld;
  logic [REG_IDX_W-1:0] r_mem_rd;
  logic                 r_wb_vld, r_wb_we;
  logic [REG_IDX_W-1:0] r_wb_rd;

  logic [REG_IDX_W-1:0] w_rs [2];
  logic [1:0]           w_used;
  logic [1:0]           w_sel [2];
  logic [1:0]           w_hz;
  logic                 w_flush;
  logic                 w_stall;
  logic                 w_iss_vld;

  assign w_rs[0]   = id_rs1_i;
  assign w_rs[1]   = id_rs2_i;
  assign w_used[0] = id_rs1_used_i;
  assign w_used[1] = id_rs2_used_i;

  // Per-operand resolve: youngest writer wins. A load in EX or MEM has no
  // data to forward yet (load data appears only at WB), so it is a hazard.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_sel[i] = 2'd0;
      w_hz[i]  = 1'b0;
      if (w_used[i] && (w_rs[i] != '0)) begin
        if (r_ex_vld && r_ex_we && (r_ex_rd == w_rs[i])) begin
          if (r_ex_ld) w_hz[i] = 1'b1;
          else         w_sel[i] = 2'd1;
        end else if (r_mem_vld && r_mem_we && (r_mem_rd == w_rs[i])) begin
          if (r_mem_ld) w_hz[i] = 1'b1;
          else          w_sel[i] = 2'd2;
        end else if (r_wb_vld && r_wb_we && (r_wb_rd == w_rs[i])) begin
          w_sel[i] = 2'd3;
        end
      end
    end
  end

  // A flush always beats a stall, so the two are mutually exclusive.
  assign w_flush   = bu_flush_i | ex_exception_i | (r_state == ST_DRAIN);
  assign w_stall   = id_valid_i & ((|w_hz) | ex_busy_i) & ~w_flush;
  assign w_iss_vld = id_valid_i & ~w_stall & ~w_flush;

  // Exception wins over everything while in DRAIN; leave only once the
  // older instructions in MEM and WB have retired.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (ex_exception_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!ex_exception_i && !r_mem_vld && !r_wb_vld) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_ex_vld  <= 1'b0;
      r_ex_we   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_vld <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_ld  <= 1'b0;
      r_mem_rd  <= '0;
      r_wb_vld  <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wb_vld <= r_mem_vld;
      r_wb_we  <= r_mem_we;
      r_wb_rd  <= r_mem_rd;
      if (ex_busy_i) begin
        // EX holds its instruction; MEM sees a bubble.
        r_mem_vld <= 1'b0;
        if (ex_exception_i) r_ex_vld <= 1'b0;
      end else begin
        // The excepting EX instruction is killed rather than advanced.
        r_mem_vld <= r_ex_vld & ~ex_exception_i;
        r_mem_we  <= r_ex_we;
        r_mem_ld  <= r_ex_ld;
        r_mem_rd  <= r_ex_rd;
        r_ex_vld  <= w_iss_vld;
        r_ex_we   <= id_we_i;
        r_ex_ld   <= id_is_load_i;
        r_ex_rd   <= id_rd_i;
      end
    end
  end

  // Reset forces every output low, independent of shadow/FSM contents.
  assign id_stall_o    = ~rst & w_stall;
  assign pd_stall_o    = ~rst & w_stall;
  assign flush_pd_o    = ~rst & w_flush;
  assign flush_id_o    = ~rst & w_flush;
  assign byp_rs1_sel_o = rst ? 2'd0 : w_sel[0];
  assign byp_rs2_sel_o = rst ? 2'd0 : w_sel[1];
  assign drain_o       = ~rst & (r_state == ST_DRAIN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-scenario stimulus tables, expected outputs via a scoreboard queue.
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
// Expected vector layout: {id_stall, pd_stall, flush_pd, flush_id, sel1[1:0], sel2[1:0], drain}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic       id_rs1_used_i;
  logic [4:0] id_rs2_i;
  logic       id_rs2_used_i;
  logic [4:0] id_rd_i;
  logic       id_we_i;
  logic       id_is_load_i;
  logic       ex_busy_i;
  logic       bu_flush_i;
  logic       ex_exception_i;
  logic       id_stall_o;
  logic       pd_stall_o;
  logic       flush_pd_o;
  logic       flush_id_o;
  logic [1:0] byp_rs1_sel_o;
  logic [1:0] byp_rs2_sel_o;
  logic       drain_o;

  int n_run  = 0;
  int n_fail = 0;
  logic [8:0] sb[$];

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       busy;
    logic       bfl;
    logic       exc;
  } stim_t;

  pipe_hazard_ctrl #(.REG_IDX_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i),
    .id_we_i(id_we_i), .id_is_load_i(id_is_load_i), .ex_busy_i(ex_busy_i),
    .bu_flush_i(bu_flush_i), .ex_exception_i(ex_exception_i),
    .id_stall_o(id_stall_o), .pd_stall_o(pd_stall_o), .flush_pd_o(flush_pd_o),
    .flush_id_o(flush_id_o), .byp_rs1_sel_o(byp_rs1_sel_o), .byp_rs2_sel_o(byp_rs2_sel_o),
    .drain_o(drain_o)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input int r, input int v, input int rs1, input int u1,
                               input int rs2, input int u2, input int rd, input int we,
                               input int ld, input int busy, input int bfl, input int exc);
    stim_t s;
    s.rst = 1'(r);   s.vld = 1'(v);
    s.rs1 = 5'(rs1); s.u1 = 1'(u1);
    s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.rd  = 5'(rd);  s.we = 1'(we); s.ld = 1'(ld);
    s.busy = 1'(busy); s.bfl = 1'(bfl); s.exc = 1'(exc);
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [8:0] E(input int stall, input int flush, input int s1,
                                   input int s2, input int drain);
    return {1'(stall), 1'(stall), 1'(flush), 1'(flush), 2'(s1), 2'(s2), 1'(drain)};
  endfunction

  function automatic logic [8:0] obs();
    return {id_stall_o, pd_stall_o, flush_pd_o, flush_id_o, byp_rs1_sel_o, byp_rs2_sel_o, drain_o};
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; id_valid_i = s.vld;
    id_rs1_i = s.rs1; id_rs1_used_i = s.u1;
    id_rs2_i = s.rs2; id_rs2_used_i = s.u2;
    id_rd_i = s.rd; id_we_i = s.we; id_is_load_i = s.ld;
    ex_busy_i = s.busy; bu_flush_i = s.bfl; ex_exception_i = s.exc;
  endtask

  task automatic test_reset();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(1, 1, 5, 1, 7, 1, 5, 1, 1, 1, 1, 1)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(idle());                                 ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 5, 1, 7, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 5, 1, 6, 1, 6, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 2, 1, 0));
    st.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 3, 2, 0));
    st.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 3, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL bypass[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 7, 1, 8, 1, 0, 0, 0, 0)); ex.push_back(E(1, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 7, 1, 8, 1, 0, 0, 0, 0)); ex.push_back(E(1, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 7, 1, 8, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 3, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest_x0();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 3, 1, 0, 1, 0, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 3, 1, 0, 1, 1, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2, 0));
    st.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL youngest_x0[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ex_busy();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(0, 1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 0)); ex.push_back(E(1, 0, 1, 0, 0));
    end
    st.push_back(mk(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 2, 1, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL ex_busy[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bu_flush();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back(E(0, 1, 0, 0, 0));
    st.push_back(mk(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(1, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 3, 0, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL bu_flush[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exception_drain();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(idle());                                  ex.push_back(E(0, 0, 0, 0, 0));
    // exception together with bu_flush; MEM holds x14, WB holds x13
    st.push_back(mk(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1, 1)); ex.push_back(E(0, 1, 2, 0, 0));
    st.push_back(mk(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 1, 3, 0, 1));
    st.push_back(mk(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 1, 0, 0, 1));
    st.push_back(mk(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    // second exception, re-raised in DRAIN, then reset
    st.push_back(mk(0, 1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(idle());                                  ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  ex.push_back(E(0, 1, 0, 0, 0));
    st.push_back(mk(0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E(0, 1, 3, 0, 1));
    st.push_back(mk(1, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin st.push_back(idle()); ex.push_back(E(0, 0, 0, 0, 0)); end
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); n_run++;
      if (got !== want) begin
        n_fail++; $display("FAIL exception_drain[%0d]: got %b required %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_load_use();
    test_youngest_x0();
    test_ex_busy();
    test_bu_flush();
    test_exception_drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
